blram_arbiter: RTL and testbench

Two-master arbiter sharing one single-port block RAM (1-cycle registered read latency, synchronous write). Sits between the CPU (master 0) and a second requester such as a DMA/loader (master 1) on one side, and the RAM's we/addr/data pins on the other. Uses round-robin ownership with a bounded burst length. Routes the read-valid back to the master that issued each read.

---
 rtl/blram_arbiter.sv | 120 ++++++++++++
 tb/tb_blram_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port block RAM with 1-cycle read latency.
// An owner keeps the RAM for at most MAXBURST accesses while the other master is waiting.
module blram_arbiter #(
   parameter int SIZE     = 14,
   parameter int DW       = 32,
   parameter int MAXBURST = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            m0_req,
   input  logic            m0_we,
   input  logic [SIZE-1:0] m0_addr,
   input  logic [DW-1:0]   m0_wdata,
   output logic            m0_gnt,
   output logic            m0_rvalid,
   output logic [DW-1:0]   m0_rdata,
   input  logic            m1_req,
   input  logic            m1_we,
   input  logic [SIZE-1:0] m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   output logic            m1_gnt,
   output logic            m1_rvalid,
   output logic [DW-1:0]   m1_rdata,
   output logic            ram_we,
   output logic [SIZE-1:0] ram_addr,
   output logic [DW-1:0]   ram_wdata,
   input  logic [DW-1:0]   ram_rdata
);

   localparam int CW = $clog2(MAXBURST) + 1;
   localparam logic [CW-1:0] CMAX = CW'(MAXBURST);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] count, count_nxt;
   logic          last, last_nxt;
   logic          rvalid0, rvalid1;

   logic          own_req, oth_req;
   logic [CW-1:0] count_inc;
   logic          burst_done;

   // Control registers, then the read-return stage one cycle after the grant
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         count   <= '0;
         last    <= 1'b1;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         last    <= last_nxt;
         rvalid0 <= m0_gnt & ~m0_we;
         rvalid1 <= m1_gnt & ~m1_we;
      end
   end

   assign m0_gnt    = (state == OWN0) & m0_req;
   assign m1_gnt    = (state == OWN1) & m1_req;
   assign m0_rvalid = rvalid0;
   assign m1_rvalid = rvalid1;
   assign m0_rdata  = ram_rdata;
   assign m1_rdata  = ram_rdata;

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      last_nxt   = last;
      own_req    = (state == OWN1) ? m1_req : m0_req;
      oth_req    = (state == OWN1) ? m0_req : m1_req;
      count_inc  = (count >= CMAX) ? CMAX : count + CW'(1);
      burst_done = own_req && (count_inc == CMAX);

      case (state)
         IDLE: begin
            // On a tie the master that did not own the RAM last wins
            if (m0_req && (!m1_req || last)) begin
               state_nxt = OWN0;
               last_nxt  = 1'b0;
               count_nxt = '0;
            end else if (m1_req) begin
               state_nxt = OWN1;
               last_nxt  = 1'b1;
               count_nxt = '0;
            end
         end
         OWN0, OWN1: begin
            if (oth_req && (burst_done || !own_req)) begin
               state_nxt = (state == OWN0) ? OWN1 : OWN0;
               last_nxt  = (state == OWN0);
               count_nxt = '0;
            end else if (!own_req) begin
               state_nxt = IDLE;
            end else begin
               count_nxt = count_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (m0_gnt) begin
         ram_we    = m0_we;
         ram_addr  = m0_addr;
         ram_wdata = m0_wdata;
      end else if (m1_gnt) begin
         ram_we    = m1_we;
         ram_addr  = m1_addr;
         ram_wdata = m1_wdata;
      end
   end

endmodule

// File: tb/tb_blram_arbiter.sv
// Bench for blram_arbiter: directed scenarios plus randomized traffic, with a memory
// reference model and per-master read-data scoreboards fed on every accepted access.
module tb_blram_arbiter;

   localparam int SIZE = 14;
   localparam int DW   = 32;
   localparam int MB   = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            m0_req, m0_we, m1_req, m1_we;
   logic [SIZE-1:0] m0_addr, m1_addr;
   logic [DW-1:0]   m0_wdata, m1_wdata;
   logic            m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [DW-1:0]   m0_rdata, m1_rdata;
   logic            ram_we;
   logic [SIZE-1:0] ram_addr;
   logic [DW-1:0]   ram_wdata;
   logic [DW-1:0]   ram_rdata;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] ram_mem   [2**SIZE];
   logic [DW-1:0] model_mem [2**SIZE];
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic [DW-1:0] mon_e;
   logic          exp_we;
   logic [SIZE-1:0] exp_addr;
   logic [DW-1:0] exp_wdata;
   int gcnt0 = 0, gcnt1 = 0;
   int w0 = 0, w1 = 0, run0 = 0, run1 = 0;

   blram_arbiter #(.SIZE(SIZE), .DW(DW), .MAXBURST(MB)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Block RAM: synchronous write, registered read
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic bound_chk(input string name, input int val, input int max);
      checks++;
      if (val > max) begin
         failures++;
         $display("FAIL %s actual=%0d required<=%0d", name, val, max);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pick(input int dens, output logic req, output logic we,
                       output logic [SIZE-1:0] addr, output logic [DW-1:0] wd);
      req = (int'($urandom_range(0, 3)) < dens);
      we  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
         0:       addr = SIZE'(100);
         1:       addr = SIZE'(500);
         default: addr = SIZE'($urandom_range(0, 15));
      endcase
      wd = DW'($urandom);
   endtask

   // Monitor: read-return scoreboard, RAM pin routing, exclusivity, fairness bounds
   always @(negedge clk) begin
      if (m0_rvalid && m1_rvalid) chk_b("rvalid_excl", 1'b1, 1'b0);
      if (m0_rvalid) begin
         if (q0.size() == 0) chk_b("rvalid0_unexpected", 1'b1, 1'b0);
         else begin
            mon_e = q0.pop_front();
            chk_w("rdata0", 64'(m0_rdata), 64'(mon_e));
         end
      end
      if (m1_rvalid) begin
         if (q1.size() == 0) chk_b("rvalid1_unexpected", 1'b1, 1'b0);
         else begin
            mon_e = q1.pop_front();
            chk_w("rdata1", 64'(m1_rdata), 64'(mon_e));
         end
      end

      chk_b("gnt_excl", m0_gnt & m1_gnt, 1'b0);
      if (m0_gnt) chk_b("gnt0_req", m0_req, 1'b1);
      if (m1_gnt) chk_b("gnt1_req", m1_req, 1'b1);

      exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
      if (m0_gnt) begin
         exp_we = m0_we; exp_addr = m0_addr; exp_wdata = m0_wdata;
      end else if (m1_gnt) begin
         exp_we = m1_we; exp_addr = m1_addr; exp_wdata = m1_wdata;
      end
      chk_b("ram_we", ram_we, exp_we);
      chk_w("ram_addr", 64'(ram_addr), 64'(exp_addr));
      chk_w("ram_wdata", 64'(ram_wdata), 64'(exp_wdata));

      if (m0_gnt) begin
         gcnt0++;
         if (m0_we) model_mem[m0_addr] = m0_wdata;
         else if (rst) q0.push_back(model_mem[m0_addr]);
      end
      if (m1_gnt) begin
         gcnt1++;
         if (m1_we) model_mem[m1_addr] = m1_wdata;
         else if (rst) q1.push_back(model_mem[m1_addr]);
      end

      if (!rst) begin
         w0 = 0; w1 = 0; run0 = 0; run1 = 0;
      end else begin
         if (m0_gnt) begin bound_chk("wait0", w0, MB + 1); w0 = 0; end
         else if (m0_req) w0++;
         else w0 = 0;
         if (m1_gnt) begin bound_chk("wait1", w1, MB + 1); w1 = 0; end
         else if (m1_req) w1++;
         else w1 = 0;
         if (m0_gnt && m1_req) begin run0++; bound_chk("burst0", run0, MB); end
         else if (m1_gnt || !m1_req) run0 = 0;
         if (m1_gnt && m0_req) begin run1++; bound_chk("burst1", run1, MB); end
         else if (m0_gnt || !m0_req) run1 = 0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int we_cnt, extra, seen0, seen1, dens, code, expc;
      logic got;
      for (int i = 0; i < 2**SIZE; i++) begin
         ram_mem[i] <= '0;
         model_mem[i] = '0;
      end
      ram_mem[500] <= DW'(32'h0000000a);
      model_mem[500] = DW'(32'h0000000a);

      rst = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = SIZE'(500); m0_wdata = '0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = SIZE'(100); m1_wdata = '0;

      // Held in reset with both requesting
      for (int c = 0; c < 3; c++) begin
         if (c > 0) tick();
         @(negedge clk);
         chk_b("t1_gnt0", m0_gnt, 1'b0);
         chk_b("t1_gnt1", m1_gnt, 1'b0);
         chk_b("t1_ram_we", ram_we, 1'b0);
         chk_b("t1_rvalid0", m0_rvalid, 1'b0);
         chk_b("t1_rvalid1", m1_rvalid, 1'b0);
      end

      // First read after reset: arbitration cycle, grant, data
      tick(); rst = 1'b1; m1_req = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = SIZE'(500);
      @(negedge clk); chk_b("t2_no_gnt_c1", m0_gnt, 1'b0);
      tick(); @(negedge clk); chk_b("t2_gnt_c2", m0_gnt, 1'b1);
      tick(); m0_req = 1'b0;
      @(negedge clk);
      chk_b("t2_rvalid0_c3", m0_rvalid, 1'b1);
      chk_w("t2_rdata0_c3", 64'(m0_rdata), 64'h0000000a);
      chk_b("t2_rvalid1_c3", m1_rvalid, 1'b0);

      // m1 write then read of the same word
      we_cnt = 0;
      tick(); m1_req = 1'b1; m1_we = 1'b1; m1_addr = SIZE'(100); m1_wdata = DW'(32'h00001234);
      @(negedge clk); chk_b("t3_no_gnt", m1_gnt, 1'b0); we_cnt += int'(ram_we);
      tick(); @(negedge clk); chk_b("t3_wr_gnt", m1_gnt, 1'b1); we_cnt += int'(ram_we);
      tick(); m1_we = 1'b0;
      @(negedge clk); chk_b("t3_rd_gnt", m1_gnt, 1'b1); we_cnt += int'(ram_we);
      tick(); m1_req = 1'b0;
      @(negedge clk);
      chk_b("t3_rvalid1", m1_rvalid, 1'b1);
      chk_w("t3_rdata1", 64'(m1_rdata), 64'h00001234);
      chk_b("t3_rvalid0", m0_rvalid, 1'b0);
      we_cnt += int'(ram_we);
      tick(); @(negedge clk); we_cnt += int'(ram_we);
      chk_w("t3_we_cycles", 64'(we_cnt), 64'd1);

      // Both request continuously: runs of MB alternate without gaps
      tick();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = SIZE'(500);
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = SIZE'(100);
      for (int c = 0; c < 1 + 3 * MB; c++) begin
         if (c > 0) tick();
         @(negedge clk);
         code = m0_gnt ? 0 : (m1_gnt ? 1 : 2);
         expc = (c == 0) ? 2 : (((c - 1) / MB) % 2);
         chk_w($sformatf("t4_owner_c%0d", c), 64'(code), 64'(expc));
      end
      tick(); m0_req = 1'b0; m1_req = 1'b0;
      @(negedge clk);

      // m0 alone for 10 accesses, then m1 joins
      tick(); m0_req = 1'b1; m0_we = 1'b0; m0_addr = SIZE'(7);
      @(negedge clk); chk_b("t5_arb_cycle", m0_gnt, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         tick(); @(negedge clk);
         chk_b($sformatf("t5_solo_gnt%0d", k), m0_gnt, 1'b1);
      end
      tick(); m1_req = 1'b1; m1_we = 1'b0; m1_addr = SIZE'(9);
      extra = 0; got = 1'b0;
      for (int k = 0; k < 2 * MB + 4; k++) begin
         @(negedge clk);
         if (m1_gnt) begin got = 1'b1; break; end
         if (m0_gnt) extra++;
         tick();
      end
      chk_b("t5_m1_granted", got, 1'b1);
      bound_chk("t5_m0_extra", extra, MB);
      tick(); m0_req = 1'b0; m1_req = 1'b0;
      @(negedge clk);

      // Reset lands on the edge of a granted read
      tick(); m0_req = 1'b1; m0_we = 1'b0; m0_addr = SIZE'(500);
      @(negedge clk); chk_b("t6_arb_cycle", m0_gnt, 1'b0);
      tick(); rst = 1'b0;
      @(negedge clk); chk_b("t6_gnt_in_rst", m0_gnt, 1'b1);
      tick(); rst = 1'b1;
      @(negedge clk);
      chk_b("t6_rvalid0_dropped", m0_rvalid, 1'b0);
      chk_b("t6_idle_no_gnt", m0_gnt, 1'b0);
      chk_w("t6_idle_addr", 64'(ram_addr), 64'd0);
      tick(); @(negedge clk); chk_b("t6_regrant", m0_gnt, 1'b1);
      tick(); m0_req = 1'b0;
      @(negedge clk); chk_b("t6_rvalid0_after", m0_rvalid, 1'b1);

      // Randomized traffic with varying request density and rare resets
      seen0 = gcnt0; seen1 = gcnt1;
      for (int n = 0; n < 3000; n++) begin
         tick();
         dens = (n / 500) % 4 + 1;
         rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         if (!m0_req || gcnt0 != seen0) pick(dens, m0_req, m0_we, m0_addr, m0_wdata);
         if (!m1_req || gcnt1 != seen1) pick(dens, m1_req, m1_we, m1_addr, m1_wdata);
         seen0 = gcnt0; seen1 = gcnt1;
      end
      tick(); rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk_w("drain_q0", 64'(q0.size()), 64'd0);
      chk_w("drain_q1", 64'(q1.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
